// File: rtl/spi_peripheral_framed.sv
// spi_peripheral_framed: chip-select-framed multi-byte SPI peripheral.
// Oversamples the SPI bus in the i_Clk domain; RX/TX bytes, frame stats.
module spi_peripheral_framed #(
    parameter int SPI_MODE         = 0,
    parameter int MAX_BYTES_PER_CS = 4,
    parameter int CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    input  logic          i_TX_DV,
    input  logic [7:0]    i_TX_Byte,
    output logic          o_TX_Ready,
    output logic          o_TX_Underrun,
    output logic          o_RX_DV,
    output logic [7:0]    o_RX_Byte,
    output logic [CW-1:0] o_RX_Count,
    output logic          o_Frame_Done,
    output logic [CW-1:0] o_Frame_Bytes,
    output logic          o_Frame_Partial,
    output logic          o_Overflow,
    input  logic          i_SPI_Clk,
    input  logic          i_SPI_PICO,
    input  logic          i_SPI_CS_n,
    output logic          o_SPI_POCI,
    output logic          o_SPI_POCI_En
);

    localparam bit CPOL = ((SPI_MODE / 2) % 2) == 1;
    localparam bit CPHA = (SPI_MODE % 2) == 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BYTES_PER_CS);

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        ACTIVE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic r_pico_s1, r_pico_s2;
    logic r_cs_s1, r_cs_s2, r_cs_d;

    logic r_ev_lead, r_ev_trail;
    logic r_ev_cs_fall, r_ev_cs_rise;
    logic r_ev_pico;

    logic [2:0]    r_bit_cnt;
    logic [CW-1:0] r_byte_cnt;
    logic [6:0]    r_rx_shift;
    logic [7:0]    r_tx_shift;
    logic [7:0]    r_hold;
    logic          r_hold_full;

    logic w_frame_start, w_frame_end;
    logic w_active, w_sample, w_shift;
    logic w_byte_done, w_load, w_tx_accept;

    // Two-flop synchronizers plus a registered edge-detect stage
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_sclk_s1    <= CPOL;
            r_sclk_s2    <= CPOL;
            r_sclk_d     <= CPOL;
            r_pico_s1    <= 1'b0;
            r_pico_s2    <= 1'b0;
            r_cs_s1      <= 1'b0;
            r_cs_s2      <= 1'b0;
            r_cs_d       <= 1'b0;
            r_ev_lead    <= 1'b0;
            r_ev_trail   <= 1'b0;
            r_ev_cs_fall <= 1'b0;
            r_ev_cs_rise <= 1'b0;
            r_ev_pico    <= 1'b0;
        end else begin
            r_sclk_s1    <= i_SPI_Clk;
            r_sclk_s2    <= r_sclk_s1;
            r_sclk_d     <= r_sclk_s2;
            r_pico_s1    <= i_SPI_PICO;
            r_pico_s2    <= r_pico_s1;
            r_cs_s1      <= i_SPI_CS_n;
            r_cs_s2      <= r_cs_s1;
            r_cs_d       <= r_cs_s2;
            r_ev_lead    <= (r_sclk_s2 != r_sclk_d) && (r_sclk_s2 != CPOL);
            r_ev_trail   <= (r_sclk_s2 != r_sclk_d) && (r_sclk_s2 == CPOL);
            r_ev_cs_fall <= r_cs_d && !r_cs_s2;
            r_ev_cs_rise <= !r_cs_d && r_cs_s2;
            r_ev_pico    <= r_pico_s2;
        end
    end

    // Frame state register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state <= WAIT_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and frame boundary strobes
    always_comb begin
        w_next        = r_state;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        unique case (r_state)
            WAIT_IDLE: begin
                if (r_cs_s2) begin
                    w_next = IDLE;
                end
            end
            IDLE: begin
                if (r_ev_cs_fall) begin
                    w_next        = ACTIVE;
                    w_frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (r_ev_cs_rise) begin
                    w_next      = IDLE;
                    w_frame_end = 1'b1;
                end
            end
            default: begin
                w_next = WAIT_IDLE;
            end
        endcase
    end

    assign w_active    = (r_state == ACTIVE);
    assign w_sample    = w_active && (CPHA ? r_ev_trail : r_ev_lead);
    assign w_shift     = w_active && (CPHA ? r_ev_lead : r_ev_trail);
    assign w_byte_done = w_sample && (r_bit_cnt == 3'd7);
    assign w_load      = w_frame_start || w_byte_done;
    assign w_tx_accept = i_TX_DV && !r_hold_full;

    assign o_TX_Ready    = !r_hold_full;
    assign o_SPI_POCI_En = w_active;
    assign o_SPI_POCI    = w_active && r_tx_shift[7];

    // RX assembly, frame bookkeeping and TX holding/shift registers.
    // A shift edge at bit count 0 is the first one after a load, where
    // the fresh MSB must stay on the wire, so it never shifts.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_bit_cnt       <= 3'd0;
            r_byte_cnt      <= '0;
            r_rx_shift      <= 7'd0;
            r_tx_shift      <= 8'd0;
            r_hold          <= 8'd0;
            r_hold_full     <= 1'b0;
            o_TX_Underrun   <= 1'b0;
            o_RX_DV         <= 1'b0;
            o_RX_Byte       <= 8'd0;
            o_RX_Count      <= '0;
            o_Frame_Done    <= 1'b0;
            o_Frame_Bytes   <= '0;
            o_Frame_Partial <= 1'b0;
            o_Overflow      <= 1'b0;
        end else begin
            o_RX_DV       <= 1'b0;
            o_Frame_Done  <= 1'b0;
            o_TX_Underrun <= 1'b0;

            if (w_frame_start) begin
                r_bit_cnt  <= 3'd0;
                r_byte_cnt <= '0;
                o_Overflow <= 1'b0;
            end

            if (w_sample) begin
                r_rx_shift <= {r_rx_shift[5:0], r_ev_pico};
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    o_RX_DV    <= 1'b1;
                    o_RX_Byte  <= {r_rx_shift, r_ev_pico};
                    o_RX_Count <= r_byte_cnt;
                    if (r_byte_cnt == MAX_CNT) begin
                        o_Overflow <= 1'b1;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + CW'(1);
                    end
                end
            end

            if (w_frame_end) begin
                o_Frame_Done    <= 1'b1;
                o_Frame_Bytes   <= r_byte_cnt;
                o_Frame_Partial <= (r_bit_cnt != 3'd0);
            end

            if (w_load) begin
                r_tx_shift    <= r_hold_full ? r_hold : 8'h00;
                o_TX_Underrun <= !r_hold_full;
                r_hold_full   <= 1'b0;
            end else if (w_shift && (r_bit_cnt != 3'd0)) begin
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
            end

            if (w_tx_accept) begin
                r_hold      <= i_TX_Byte;
                r_hold_full <= 1'b1;
            end
        end
    end

endmodule
